// File: rtl/mem_arbiter_pkg.sv
// Shared bus constants and arbiter encodings for the fetch/data SRAM port.
package mem_arbiter_pkg;
  localparam int BUS_AW               = 32;
  localparam int BUS_WEN_W            = 4;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  // Which requester owns the response returning on the cycle after an issue.
  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_INST    = 2'd1,
    OWN_DATA_LD = 2'd2
  } owner_e;

  typedef struct packed {
    logic inst;
    logic data;
  } grant_t;

  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/mem_arbiter_prio.sv
// Combinational winner select with a saturating counter that bounds how long
// a waiting fetch can be passed over by data accesses.
module mem_arbiter_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   d_req,
  output grant_t grant
);
  localparam int CW = cnt_w(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    grant = '0;
    if (d_req && !(i_req && starved)) grant.data = 1'b1;
    else if (i_req)                   grant.inst = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         starve_cnt <= '0;
    else if (!i_req || grant.inst)    starve_cnt <= '0;
    else if (grant.data && !starved)  starve_cnt <= starve_cnt + CW'(1);
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access;
// data has priority, with a starvation bound for fetch. Read latency is 1.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int AW           = BUS_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [AW-1:0]        i_addr,
  output logic                 i_ack,
  output logic                 i_rvalid,
  input  logic                 d_req,
  input  logic [BUS_WEN_W-1:0] d_wen,
  input  logic [AW-1:0]        d_addr,
  input  logic [AW-1:0]        d_wdata,
  output logic                 d_ack,
  output logic                 d_rvalid,
  output logic [AW-1:0]        rdata,
  output logic                 mem_en,
  output logic [BUS_WEN_W-1:0] mem_wen,
  output logic [AW-1:0]        mem_addr,
  output logic [AW-1:0]        mem_wdata,
  input  logic [AW-1:0]        mem_rdata,
  output logic                 stallreq_for_mem
);
  logic   i_req_g, d_req_g;
  grant_t grant;
  owner_e owner, owner_nxt;

  // Requests are masked while reset is held so every output reads zero.
  assign i_req_g = rst & i_req;
  assign d_req_g = rst & d_req;

  mem_arbiter_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk   (clk),
    .rst   (rst),
    .i_req (i_req_g),
    .d_req (d_req_g),
    .grant (grant)
  );

  always_comb begin
    i_ack     = grant.inst;
    d_ack     = grant.data;
    mem_en    = grant.inst | grant.data;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_nxt = OWN_NONE;
    if (grant.data) begin
      mem_wen   = d_wen;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      if (d_wen == '0) owner_nxt = OWN_DATA_LD;
    end else if (grant.inst) begin
      mem_addr  = i_addr;
      owner_nxt = OWN_INST;
    end
  end

  // Stores get no response, so only loads and fetches claim the return slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) owner <= OWN_NONE;
    else      owner <= owner_nxt;
  end

  always_comb begin
    i_rvalid = (owner == OWN_INST);
    d_rvalid = (owner == OWN_DATA_LD);
    rdata    = (i_rvalid | d_rvalid) ? mem_rdata : '0;
  end

  assign stallreq_for_mem = (i_req_g & ~grant.inst) | (d_req_g & ~grant.data) |
                            (owner != OWN_NONE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency SRAM model.
module tb_mem_arbiter;
  logic        clk, rst;
  logic        i_req, i_ack, i_rvalid;
  logic [31:0] i_addr;
  logic        d_req, d_ack, d_rvalid;
  logic [3:0]  d_wen;
  logic [31:0] d_addr, d_wdata, rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stallreq_for_mem;
  int          checks, failures;

  mem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stallreq_for_mem(stallreq_for_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'h5A5A_A5A5);
  endfunction

  always @(posedge clk) mem_rdata <= mem_en ? mem_fn(mem_addr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h1234_5678;
    d_req = 1'b1; d_wen = 4'hF; d_addr = 32'h55; d_wdata = 32'hFFFF_FFFF;

    // reset forces outputs low even with requests high
    smp;
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_stall", stallreq_for_mem, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    nxt;
    i_req = 1'b0; d_req = 1'b0; d_wen = 4'h0; d_wdata = 32'h0;
    rst = 1'b1;
    nxt;

    // single fetch
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    smp;
    chk1("f_i_ack", i_ack, 1'b1);
    chk1("f_mem_en", mem_en, 1'b1);
    chk("f_mem_addr", mem_addr, 32'hBFC0_0000);
    chk1("f_i_rvalid0", i_rvalid, 1'b0);
    nxt;
    i_req = 1'b0;
    smp;
    chk1("f_i_rvalid", i_rvalid, 1'b1);
    chk("f_rdata", rdata, 32'h2408_0001);
    chk1("f_d_rvalid", d_rvalid, 1'b0);
    chk1("f_mem_en_idle", mem_en, 1'b0);
    nxt;
    smp;
    chk1("f_stall_after", stallreq_for_mem, 1'b0);
    chk1("f_i_rvalid_after", i_rvalid, 1'b0);
    chk("f_rdata_after", rdata, 32'h0);
    nxt;

    // simultaneous fetch and load: data first
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    smp;
    chk1("both_d_ack", d_ack, 1'b1);
    chk1("both_i_ack", i_ack, 1'b0);
    chk("both_addr", mem_addr, 32'h200);
    chk1("both_stall", stallreq_for_mem, 1'b1);
    nxt;
    d_req = 1'b0;
    smp;
    chk1("both_i_ack2", i_ack, 1'b1);
    chk1("both_d_rvalid", d_rvalid, 1'b1);
    chk("both_d_rdata", rdata, mem_fn(32'h200));
    chk("both_i_wdata", mem_wdata, 32'h0);
    chk("both_i_addr", mem_addr, 32'h100);
    nxt;
    i_req = 1'b0;
    smp;
    chk1("both_i_rvalid", i_rvalid, 1'b1);
    chk1("both_d_rvalid_off", d_rvalid, 1'b0);
    chk("both_i_rdata", rdata, mem_fn(32'h100));
    nxt;

    // store: no response
    d_req = 1'b1; d_wen = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    smp;
    chk1("st_d_ack", d_ack, 1'b1);
    chk("st_mem_wen", {28'h0, mem_wen}, 32'hF);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_addr", mem_addr, 32'h10);
    nxt;
    d_req = 1'b0; d_wen = 4'h0;
    smp;
    chk1("st_no_rvalid", d_rvalid, 1'b0);
    chk1("st_stall", stallreq_for_mem, 1'b0);
    chk("st_rdata", rdata, 32'h0);
    nxt;

    // starvation bound: data 0-3, inst 4, data 5
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h400;
    for (int c = 0; c < 6; c++) begin
      smp;
      chk1($sformatf("sv_d_ack%0d", c), d_ack, c != 4);
      chk1($sformatf("sv_i_ack%0d", c), i_ack, c == 4);
      if (c == 4) chk("sv_i_wdata", mem_wdata, 32'h0);
      if (c == 5) chk1("sv_i_rvalid", i_rvalid, 1'b1);
      nxt;
      if (c == 4) i_req = 1'b0;
    end
    d_req = 1'b0;
    nxt;

    // reset one cycle after a load issue, with a partly-filled counter
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_addr = 32'h600;
    nxt; nxt; nxt;
    rst = 1'b0;
    smp;
    chk1("mr_d_rvalid", d_rvalid, 1'b0);
    chk1("mr_d_ack", d_ack, 1'b0);
    chk1("mr_mem_en", mem_en, 1'b0);
    chk1("mr_stall", stallreq_for_mem, 1'b0);
    chk("mr_rdata", rdata, 32'h0);
    nxt;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      smp;
      if (c == 0) chk1("mr_no_stale", d_rvalid, 1'b0);
      chk1($sformatf("mr_d_ack%0d", c), d_ack, c != 4);
      chk1($sformatf("mr_i_ack%0d", c), i_ack, c == 4);
      nxt;
      if (c == 4) begin i_req = 1'b0; d_req = 1'b0; end
    end
    nxt;

    // eight back-to-back fetches
    for (int k = 0; k < 10; k++) begin
      i_req  = (k < 8);
      i_addr = 32'h1000 + 32'(4 * k);
      smp;
      if (k < 8) begin
        chk1($sformatf("b2b_ack%0d", k), i_ack, 1'b1);
        chk($sformatf("b2b_addr%0d", k), mem_addr, 32'h1000 + 32'(4 * k));
      end
      if (k >= 1 && k <= 8) begin
        chk1($sformatf("b2b_rv%0d", k), i_rvalid, 1'b1);
        chk($sformatf("b2b_rd%0d", k), rdata, mem_fn(32'h1000 + 32'(4 * (k - 1))));
      end
      if (k == 9) chk1("b2b_rv_end", i_rvalid, 1'b0);
      nxt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
